seven_segment_scanner: RTL and testbench
========================================

SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The block SHALL have parameter DIGITS, default 4, giving the number of multiplexed digits (2..8).
REQ-002 The block SHALL have parameter SLOT_CYCLES, default 1000, giving clock cycles per digit slot (>= BLANK_CYCLES+1).
REQ-003 The block SHALL have parameter BLANK_CYCLES, default 2, giving anti-ghost blank cycles at the start of each slot (>= 1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-005 The block SHALL have port n_reset, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port data_in, input, 4*DIGITS bits: BCD digits, with digit 0 (least significant) in bits [3:0].
REQ-007 The block SHALL have port load, input, 1 bit: capture strobe for data_in.
REQ-008 The block SHALL have port lzb, input, 1 bit: leading-zero blanking enable.
REQ-009 The block SHALL have port bcd, output, 4 bits: code to the shared BcdSevenSegment decoder.
REQ-010 The block SHALL have port n_enable, output, 1 bit: active-low decoder enable.
REQ-011 The block SHALL have port n_digit, output, DIGITS bits: active-low digit-common select, one-hot-low or all-high.
REQ-012 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at the start of digit 0's slot.
REQ-013 The block SHALL have port bcd_err, output, 1 bit: high while the digit being shown holds a code greater than 9.

Function
REQ-014 The block SHALL time-share one decoder across DIGITS digits, visiting index 0,1,...,DIGITS-1 and then wrapping to 0.
REQ-015 The FSM SHALL have states BLANK and SHOW, with slot counter slot_cnt running 0..SLOT_CYCLES-1.
REQ-016 The FSM SHALL be in BLANK while slot_cnt < BLANK_CYCLES and in SHOW otherwise; at slot_cnt = SLOT_CYCLES-1 the counter SHALL wrap to 0 and the digit index SHALL advance.
REQ-017 All outputs SHALL be registered, reflecting the state, index and slot_cnt of the same cycle with one cycle latency.
REQ-018 In BLANK, the block SHALL drive n_digit all-ones, n_enable=1, and hold bcd.
REQ-019 In SHOW, the block SHALL drive n_digit[idx]=0 with all other bits 1, bcd = display[idx], and n_enable=0 unless the digit is suppressed.
REQ-020 A digit SHALL be suppressed (n_enable=1, n_digit still asserted) when its code is greater than 9, or when lzb=1 and it and all more-significant digits equal 0.
REQ-021 Digit 0 SHALL never be zero-suppressed.
REQ-022 bcd_err SHALL be 1 in SHOW cycles showing a code greater than 9, and 0 otherwise.
REQ-023 load=1 SHALL capture data_in into a pending register and set pending_valid; a later load before transfer SHALL overwrite it.
REQ-024 At a frame boundary (idx=0, slot_cnt=0), a set pending_valid SHALL transfer pending into display and clear pending_valid.
REQ-025 When load coincides with a frame boundary, data_in SHALL go directly to display and pending_valid SHALL clear.
REQ-026 Display contents SHALL never change mid-frame.
REQ-027 frame_start SHALL pulse once per frame, exactly DIGITS*SLOT_CYCLES cycles apart.

Reset
REQ-028 On a clk edge with n_reset=0, the block SHALL set state BLANK, idx=0, slot_cnt=0, display=0, pending=0 and pending_valid=0.
REQ-029 Under reset, outputs SHALL be bcd=0, n_enable=1, n_digit all-ones, frame_start=0 and bcd_err=0.
REQ-030 When reset is applied mid-slot, outputs SHALL blank on the next edge, and the first cycle after release SHALL be slot_cnt=0, idx=0 of a new frame, with frame_start asserted one cycle later.

Structure
REQ-031 State encodings (BLANK, SHOW) and the BCD_MAX=9 constant SHALL reside in a shared constants include used by the display blocks.
REQ-032 Slot/digit counting SHALL be a sub-module scan_counter, parameterised DIGITS and SLOT_CYCLES, outputting idx, slot_cnt and the frame boundary.
REQ-033 The decoder SHALL NOT be instantiated inside the block; the integrator connects bcd and n_enable to BcdSevenSegment.

Verification (DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-034 Reset, then load 16'h1234 -> next frame SHALL show digit 0 with bcd=4, n_digit=1110 over 6 SHOW cycles after 2 blank cycles, followed by 3, 2, 1; frame_start SHALL pulse every 32 cycles.
REQ-035 lzb=1, data 16'h0070 -> digits 3 and 2 SHALL be n_enable=1 and digit 1 SHALL be bcd=7, n_enable=0; digit 0 SHALL show bcd=0, n_enable=0; with lzb=0 all four SHALL be enabled.
REQ-036 Data 16'h00A5 -> the digit 1 slot SHALL show bcd_err=1 and n_enable=1 for 6 cycles; other digits SHALL show bcd_err=0.
REQ-037 Loads of 16'h1111 and then 16'h2222 mid-frame -> the current frame SHALL be unchanged and the next frame SHALL show 2222; a load coinciding with the frame boundary SHALL take effect in that frame.
REQ-038 n_reset=0 during the digit 2 SHOW phase -> n_digit SHALL be 1111 on the next edge; after release the display SHALL be 0 and the frame SHALL restart at idx 0.
REQ-039 The bench SHALL check, every cycle, that at most one n_digit bit is low and that n_digit=1111 in all BLANK cycles.

Source files
------------

// File: rtl/seven_segment_scanner_pkg.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner_pkg
//   Constants shared by the multiplexed display blocks.
//   - scan_state_e : slot phase (BLANK = anti-ghost gap, SHOW = digit driven)
//   - BCD_MAX      : largest legal BCD code
//   - is_bad_code  : true for codes the decoder cannot render (10..15)
// ---------------------------------------------------------------------------
package seven_segment_scanner_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bad_code(input logic [3:0] code);
    return code > BCD_MAX;
  endfunction

endpackage

// File: rtl/seven_segment_scanner_if.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner_if
//   Data/strobe inputs and display-drive outputs of the scanner.
//   data_in     : DIGITS packed BCD nibbles, digit 0 in [3:0]
//   load        : capture strobe for data_in
//   lzb         : leading-zero blanking enable
//   bcd         : code to the shared BCD-to-7-segment decoder
//   n_enable    : active-low decoder enable
//   n_digit     : active-low digit-common select (one low or all high)
//   frame_start : one-cycle pulse at the start of digit 0's slot
//   bcd_err     : digit being shown holds a code > 9
//   master = producer of data / consumer of drive, slave = scanner.
// ---------------------------------------------------------------------------
interface seven_segment_scanner_if #(
  parameter int DIGITS = 4
);

  logic [4*DIGITS-1:0] data_in;
  logic                load;
  logic                lzb;
  logic [3:0]          bcd;
  logic                n_enable;
  logic [DIGITS-1:0]   n_digit;
  logic                frame_start;
  logic                bcd_err;

  modport master (
    output data_in, load, lzb,
    input  bcd, n_enable, n_digit, frame_start, bcd_err
  );

  modport slave (
    input  data_in, load, lzb,
    output bcd, n_enable, n_digit, frame_start, bcd_err
  );

endinterface

// File: rtl/seven_segment_scanner_scan_counter.sv
// ---------------------------------------------------------------------------
// scan_counter
//   Slot and digit-index counter for the display multiplexer.
//   clk, n_reset : clock, synchronous active-low reset
//   idx          : digit currently owning the slot, 0..DIGITS-1
//   slot_cnt     : cycle within the slot, 0..SLOT_CYCLES-1
//   slot_last    : last cycle of the slot (idx advances after it)
//   frame_bound  : first cycle of a frame (idx = 0, slot_cnt = 0)
// ---------------------------------------------------------------------------
module scan_counter #(
  parameter  int DIGITS      = 4,
  parameter  int SLOT_CYCLES = 1000,
  localparam int IDX_W       = $clog2(DIGITS),
  localparam int CNT_W       = $clog2(SLOT_CYCLES)
) (
  input  logic             clk,
  input  logic             n_reset,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] slot_cnt,
  output logic             slot_last,
  output logic             frame_bound
);

  assign slot_last   = (slot_cnt == CNT_W'(SLOT_CYCLES - 1));
  assign frame_bound = (idx == '0) && (slot_cnt == '0);

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      idx      <= '0;
      slot_cnt <= '0;
    end else if (slot_last) begin
      slot_cnt <= '0;
      idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end else begin
      slot_cnt <= slot_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// seven_segment_scanner
//   Time-shares one external BCD-to-7-segment decoder across DIGITS digits.
//   Each digit owns a slot of SLOT_CYCLES cycles; the first BLANK_CYCLES of
//   every slot drive nothing so the previous digit's segments can decay
//   before the next common is selected (anti-ghosting).
//   Ports:
//     clk     : clock, rising edge
//     n_reset : synchronous active-low reset
//     bus     : data_in/load/lzb in, bcd/n_enable/n_digit/frame_start/bcd_err
//               out (see seven_segment_scanner_if)
//   New data is staged in a pending register and only moved into the shown
//   register at a frame boundary, so a frame never mixes old and new digits.
//   All outputs are registered: they show the previous cycle's state/idx.
// ---------------------------------------------------------------------------
module seven_segment_scanner
  import seven_segment_scanner_pkg::*;
#(
  parameter int DIGITS       = 4,
  parameter int SLOT_CYCLES  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     n_reset,
  seven_segment_scanner_if.slave   bus
);

  localparam int IDX_W = $clog2(DIGITS);
  localparam int CNT_W = $clog2(SLOT_CYCLES);

  // -------------------------------------------------------------------------
  // slot / digit sequencing
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] slot_cnt;
  logic             slot_last;
  logic             frame_bound;

  scan_counter #(
    .DIGITS      (DIGITS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_scan (
    .clk         (clk),
    .n_reset     (n_reset),
    .idx         (idx),
    .slot_cnt    (slot_cnt),
    .slot_last   (slot_last),
    .frame_bound (frame_bound)
  );

  // -------------------------------------------------------------------------
  // data staging
  // -------------------------------------------------------------------------
  logic [DIGITS-1:0][3:0] display_q;
  logic [DIGITS-1:0][3:0] pending_q;
  logic                   pending_valid_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      display_q       <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else if (frame_bound) begin
      // The boundary cycle is always blank, so swapping here is invisible.
      // A coincident load wins over anything still pending.
      if (bus.load)             display_q <= bus.data_in;
      else if (pending_valid_q) display_q <= pending_q;
      pending_valid_q <= 1'b0;
    end else if (bus.load) begin
      pending_q       <= bus.data_in;
      pending_valid_q <= 1'b1;
    end
  end

  // upper_zero[k]: digit k and every more-significant digit are zero
  logic [DIGITS-1:0] upper_zero;
  logic              zero_acc;

  always_comb begin
    upper_zero = '0;
    zero_acc   = 1'b1;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_acc      = zero_acc && (display_q[k] == 4'd0);
      upper_zero[k] = zero_acc;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: BLANK for the first BLANK_CYCLES of a slot, SHOW for the rest.
  // state_q tracks the current slot_cnt, so next state follows the next count.
  // -------------------------------------------------------------------------
  scan_state_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (!n_reset) state_q <= BLANK;
    else          state_q <= state_d;
  end

  logic [3:0]        cur_code;
  logic [3:0]        bcd_d;
  logic              n_enable_d;
  logic [DIGITS-1:0] n_digit_d;
  logic              bcd_err_d;

  assign cur_code = display_q[idx];

  always_comb begin
    state_d    = state_q;
    bcd_d      = bus.bcd;          // bcd holds through blank
    n_enable_d = 1'b1;
    n_digit_d  = '1;
    bcd_err_d  = 1'b0;

    if (slot_last)                              state_d = BLANK;
    else if (int'(slot_cnt) + 1 < BLANK_CYCLES) state_d = BLANK;
    else                                        state_d = SHOW;

    if (state_q == SHOW) begin
      bcd_d      = cur_code;
      n_digit_d  = ~(DIGITS'(1) << idx);
      bcd_err_d  = is_bad_code(cur_code);
      // Digit 0 is exempt from leading-zero blanking so "0" still shows.
      n_enable_d = bcd_err_d || (bus.lzb && (idx != '0) && upper_zero[idx]);
    end
  end

  // -------------------------------------------------------------------------
  // output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      bus.bcd         <= 4'd0;
      bus.n_enable    <= 1'b1;
      bus.n_digit     <= '1;
      bus.frame_start <= 1'b0;
      bus.bcd_err     <= 1'b0;
    end else begin
      bus.bcd         <= bcd_d;
      bus.n_enable    <= n_enable_d;
      bus.n_digit     <= n_digit_d;
      bus.frame_start <= frame_bound;
      bus.bcd_err     <= bcd_err_d;
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_scanner
//   Directed scenarios plus randomized traffic for seven_segment_scanner
//   (DIGITS=4, SLOT_CYCLES=8, BLANK_CYCLES=2). A frame-position model tracks
//   the expected outputs of every cycle; scenario tasks add targeted checks.
// ---------------------------------------------------------------------------
module tb_seven_segment_scanner;

  localparam int DIG   = 4;
  localparam int SLOT  = 8;
  localparam int BLK   = 2;
  localparam int FRAME = DIG * SLOT;

  logic clk;
  logic n_reset;

  seven_segment_scanner_if #(.DIGITS(DIG)) bus ();

  seven_segment_scanner #(
    .DIGITS       (DIG),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLK)
  ) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // -------------------------------------------------------------------------
  // reference model: position within the frame, shown and staged words
  // -------------------------------------------------------------------------
  int                pos;
  logic [4*DIG-1:0]  disp_m, pend_m;
  logic              pv_m;
  logic              mon_en = 1'b0;
  logic [3:0]        exp_bcd;
  logic              exp_nen, exp_fs, exp_err;
  logic [DIG-1:0]    exp_ndig;

  function automatic logic [3:0] nib(input logic [4*DIG-1:0] v, input int i);
    return v[4*i +: 4];
  endfunction

  function automatic logic hidden(input logic [4*DIG-1:0] v, input int i,
                                  input logic lz);
    return (nib(v, i) > 4'd9) || (lz && i > 0 && (v >> (4 * i)) == '0);
  endfunction

  always @(posedge clk) begin
    mon_en <= 1'b1;
    if (!n_reset) begin
      pos      <= 0;
      disp_m   <= '0;
      pend_m   <= '0;
      pv_m     <= 1'b0;
      exp_bcd  <= 4'd0;
      exp_nen  <= 1'b1;
      exp_ndig <= '1;
      exp_fs   <= 1'b0;
      exp_err  <= 1'b0;
    end else begin
      exp_fs <= (pos == 0);
      if ((pos % SLOT) < BLK) begin
        exp_ndig <= '1;
        exp_nen  <= 1'b1;
        exp_err  <= 1'b0;
      end else begin
        exp_bcd  <= nib(disp_m, pos / SLOT);
        exp_err  <= nib(disp_m, pos / SLOT) > 4'd9;
        exp_nen  <= hidden(disp_m, pos / SLOT, bus.lzb);
        exp_ndig <= ~(DIG'(1) << (pos / SLOT));
      end
      if (pos == 0) begin
        if (bus.load)  disp_m <= bus.data_in;
        else if (pv_m) disp_m <= pend_m;
        pv_m <= 1'b0;
      end else if (bus.load) begin
        pend_m <= bus.data_in;
        pv_m   <= 1'b1;
      end
      pos <= (pos + 1) % FRAME;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      n_tests++;
      if ({bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err} !==
          {exp_bcd, exp_nen, exp_ndig, exp_fs, exp_err}) begin
        n_fail++;
        $display("FAIL model t=%0t got bcd=%h nen=%b ndig=%b fs=%b err=%b want bcd=%h nen=%b ndig=%b fs=%b err=%b",
                 $time, bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err,
                 exp_bcd, exp_nen, exp_ndig, exp_fs, exp_err);
      end
      n_tests++;
      if ($countones(~bus.n_digit) > 1) begin
        n_fail++;
        $display("FAIL onehot t=%0t got n_digit=%b want at most one low", $time, bus.n_digit);
      end
    end
  end

  // -------------------------------------------------------------------------
  // helpers
  // -------------------------------------------------------------------------
  task automatic wait_fs(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < max_cyc; n++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_load(input logic [4*DIG-1:0] v);
    bus.data_in = v;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
  endtask

  // -------------------------------------------------------------------------
  // scenarios
  // -------------------------------------------------------------------------
  task automatic test_reset();
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err} !== {4'd0, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_outputs got bcd=%h nen=%b ndig=%b fs=%b err=%b want 0 1 1111 0 0",
               bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err);
    end
    n_reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_frame got frame_start=%b want 1", bus.frame_start);
    end
  endtask

  task automatic test_basic();
    bit ok;
    logic [15:0] v = 16'h1234;
    logic [3:0]  exp_nd;
    int i, s;
    wait_fs(2 * FRAME, ok);
    pulse_load(v);
    wait_fs(2 * FRAME, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL basic_wait got no frame_start want one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      i = j / SLOT;
      s = j % SLOT;
      exp_nd = (s < BLK) ? 4'hF : ~(4'b0001 << i);
      n_tests++;
      if (bus.n_digit !== exp_nd) begin
        n_fail++;
        $display("FAIL basic_ndig j=%0d got %b want %b", j, bus.n_digit, exp_nd);
      end
      if (s >= BLK) begin
        n_tests++;
        if (bus.bcd !== v[4*i +: 4] || bus.n_enable !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_digit j=%0d got bcd=%h nen=%b want bcd=%h nen=0", j, bus.bcd, bus.n_enable, v[4*i +: 4]);
        end
      end
      n_tests++;
      if (bus.frame_start !== (j == 0)) begin
        n_fail++;
        $display("FAIL basic_fs j=%0d got %b want %b", j, bus.frame_start, j == 0);
      end
    end
    @(negedge clk);
    n_tests++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_period got frame_start=%b want 1 after %0d cycles", bus.frame_start, FRAME);
    end
  endtask

  task automatic test_lzb();
    bit ok;
    int i;
    bus.lzb = 1'b1;
    pulse_load(16'h0070);
    wait_fs(2 * FRAME, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL lzb_wait got no frame_start want one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      i = j / SLOT;
      if (j % SLOT == 5) begin
        n_tests++;
        if (bus.n_enable !== (i >= 2) || (i < 2 && bus.bcd !== ((i == 1) ? 4'd7 : 4'd0))) begin
          n_fail++;
          $display("FAIL lzb_on digit=%0d got bcd=%h nen=%b want nen=%b", i, bus.bcd, bus.n_enable, i >= 2);
        end
      end
    end
    bus.lzb = 1'b0;
    wait_fs(2 * FRAME, ok);
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      i = j / SLOT;
      if (j % SLOT == 5) begin
        n_tests++;
        if (bus.n_enable !== 1'b0 || bus.bcd !== ((i == 1) ? 4'd7 : 4'd0)) begin
          n_fail++;
          $display("FAIL lzb_off digit=%0d got bcd=%h nen=%b want nen=0", i, bus.bcd, bus.n_enable);
        end
      end
    end
  endtask

  task automatic test_bcd_err();
    bit ok;
    int i, s, errs;
    errs = 0;
    pulse_load(16'h00A5);
    wait_fs(2 * FRAME, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL err_wait got no frame_start want one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      i = j / SLOT;
      s = j % SLOT;
      if (bus.bcd_err === 1'b1) errs++;
      n_tests++;
      if (bus.bcd_err !== (s >= BLK && i == 1)) begin
        n_fail++;
        $display("FAIL err_flag j=%0d got %b want %b", j, bus.bcd_err, s >= BLK && i == 1);
      end
      if (s >= BLK && i == 1) begin
        n_tests++;
        if (bus.n_enable !== 1'b1 || bus.bcd !== 4'hA) begin
          n_fail++;
          $display("FAIL err_digit j=%0d got bcd=%h nen=%b want bcd=a nen=1", j, bus.bcd, bus.n_enable);
        end
      end
    end
    n_tests++;
    if (errs != SLOT - BLK) begin
      n_fail++;
      $display("FAIL err_count got %0d want %0d", errs, SLOT - BLK);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int i, s;
    logic [15:0] cur = 16'h00A5;
    logic [15:0] nxt = 16'h2222;
    logic [15:0] bnd = 16'h3456;
    wait_fs(2 * FRAME, ok);
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      if (j == 3)  begin bus.data_in = 16'h1111; bus.load = 1'b1; end
      if (j == 4)  bus.load = 1'b0;
      if (j == 10) begin bus.data_in = 16'h2222; bus.load = 1'b1; end
      if (j == 11) bus.load = 1'b0;
      i = j / SLOT;
      s = j % SLOT;
      if (s >= BLK) begin
        n_tests++;
        if (bus.bcd !== cur[4*i +: 4]) begin
          n_fail++;
          $display("FAIL b2b_hold j=%0d got bcd=%h want %h", j, bus.bcd, cur[4*i +: 4]);
        end
      end
    end
    wait_fs(2 * FRAME, ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL b2b_wait got no frame_start want one"); end
    for (int j = 0; j < FRAME; j++) begin
      if (j > 0) @(negedge clk);
      i = j / SLOT;
      s = j % SLOT;
      if (s >= BLK) begin
        n_tests++;
        if (bus.bcd !== nxt[4*i +: 4]) begin
          n_fail++;
          $display("FAIL b2b_next j=%0d got bcd=%h want %h", j, bus.bcd, nxt[4*i +: 4]);
        end
      end
    end
    // now at the last position of the frame: load lands on the boundary cycle
    bus.data_in = bnd;
    bus.load    = 1'b1;
    @(negedge clk);
    bus.load    = 1'b0;
    n_tests++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_bound_fs got %b want 1", bus.frame_start);
    end
    for (int j = 1; j < FRAME; j++) begin
      @(negedge clk);
      i = j / SLOT;
      s = j % SLOT;
      if (s >= BLK) begin
        n_tests++;
        if (bus.bcd !== bnd[4*i +: 4]) begin
          n_fail++;
          $display("FAIL b2b_boundary j=%0d got bcd=%h want %h", j, bus.bcd, bnd[4*i +: 4]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int i, s;
    wait_fs(2 * FRAME, ok);
    repeat (2 * SLOT + 4) @(negedge clk);
    n_tests++;
    if (bus.n_digit !== 4'b1011) begin
      n_fail++;
      $display("FAIL rst_pre got n_digit=%b want 1011", bus.n_digit);
    end
    n_reset = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err} !== {4'd0, 1'b1, 4'hF, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_mid got bcd=%h nen=%b ndig=%b fs=%b err=%b want 0 1 1111 0 0",
               bus.bcd, bus.n_enable, bus.n_digit, bus.frame_start, bus.bcd_err);
    end
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if (bus.frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart got frame_start=%b want 1", bus.frame_start);
    end
    for (int j = 1; j < FRAME; j++) begin
      @(negedge clk);
      i = j / SLOT;
      s = j % SLOT;
      if (s >= BLK) begin
        n_tests++;
        if (bus.bcd !== 4'd0 || bus.n_enable !== 1'b0 || bus.n_digit !== ~(4'b0001 << i)) begin
          n_fail++;
          $display("FAIL rst_cleared j=%0d got bcd=%h nen=%b ndig=%b want bcd=0 nen=0 idx=%0d",
                   j, bus.bcd, bus.n_enable, bus.n_digit, i);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      bus.lzb     = 1'($urandom_range(0, 1));
      bus.load    = ($urandom_range(0, 7) == 0);
      bus.data_in = 16'($urandom) >> (4 * $urandom_range(0, 3));
      n_reset     = !(n >= 300 && n < 302);
    end
    @(negedge clk);
    bus.load = 1'b0;
    n_reset  = 1'b1;
    repeat (FRAME) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog t=%0t got no finish want finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_reset     = 1'b0;
    bus.data_in = '0;
    bus.load    = 1'b0;
    bus.lzb     = 1'b0;
    test_reset();
    test_basic();
    test_lzb();
    test_bcd_err();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
